// File: rtl/register_file.sv
// 32 x DATA_WIDTH two-read/one-write register file, x0 hardwired to zero.
// Reads are combinational with no write bypass; a write lands on the rising edge and reset overrides it.
module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  regWrite,
   input  logic [ADDR_WIDTH-1:0] readAddr0,
   input  logic [ADDR_WIDTH-1:0] readAddr1,
   input  logic [ADDR_WIDTH-1:0] writeAddr,
   input  logic [DATA_WIDTH-1:0] dataIn,
   output logic [DATA_WIDTH-1:0] dataOut0,
   output logic [DATA_WIDTH-1:0] dataOut1
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] regs_d [DEPTH];

   // Entry 0 is never written, and the read mux masks it so x0 is zero even before reset.
   always_comb begin
      regs_d = regs_q;
      if (regWrite && (writeAddr != '0)) begin
         regs_d[writeAddr] = dataIn;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   assign dataOut0 = (readAddr0 == '0) ? '0 : regs_q[readAddr0];
   assign dataOut1 = (readAddr1 == '0) ? '0 : regs_q[readAddr1];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, writes, same-address read/write, x0, write disable, reset priority.
module tb_register_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        regWrite;
   logic [4:0]  readAddr0;
   logic [4:0]  readAddr1;
   logic [4:0]  writeAddr;
   logic [31:0] dataIn;
   logic [31:0] dataOut0;
   logic [31:0] dataOut1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .regWrite  (regWrite),
      .readAddr0 (readAddr0),
      .readAddr1 (readAddr1),
      .writeAddr (writeAddr),
      .dataIn    (dataIn),
      .dataOut0  (dataOut0),
      .dataOut1  (dataOut1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; regWrite = 1'b0; writeAddr = 5'd0; dataIn = 32'd0;
      readAddr0 = 5'd0; readAddr1 = 5'd0;
      #1;
      checks++;
      if (dataOut0 !== 32'd0) begin
         errors++; $display("FAIL x0_before_reset_rd0 got=%0h exp=0", dataOut0);
      end
      checks++;
      if (dataOut1 !== 32'd0) begin
         errors++; $display("FAIL x0_before_reset_rd1 got=%0h exp=0", dataOut1);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      readAddr0 = 5'd5; readAddr1 = 5'd31;
      #1;
      checks++;
      if (dataOut0 !== 32'd0) begin
         errors++; $display("FAIL reset_rd0_addr5 got=%0h exp=0", dataOut0);
      end
      checks++;
      if (dataOut1 !== 32'd0) begin
         errors++; $display("FAIL reset_rd1_addr31 got=%0h exp=0", dataOut1);
      end
   endtask

   task automatic test_seq_write();
      regWrite = 1'b1;
      writeAddr = 5'd5;  dataIn = 32'd879;  step();
      writeAddr = 5'd2;  dataIn = 32'd512;  step();
      writeAddr = 5'd23; dataIn = 32'd6549; step();
      regWrite = 1'b0;
      readAddr0 = 5'd2; readAddr1 = 5'd23;
      #1;
      checks++;
      if (dataOut0 !== 32'd512) begin
         errors++; $display("FAIL seq_rd0_addr2 got=%0d exp=512", dataOut0);
      end
      checks++;
      if (dataOut1 !== 32'd6549) begin
         errors++; $display("FAIL seq_rd1_addr23 got=%0d exp=6549", dataOut1);
      end
      readAddr0 = 5'd5;
      #1;
      checks++;
      if (dataOut0 !== 32'd879) begin
         errors++; $display("FAIL seq_rd0_addr5 got=%0d exp=879", dataOut0);
      end
   endtask

   task automatic test_same_addr();
      regWrite = 1'b1; writeAddr = 5'd5; dataIn = 32'd36; readAddr0 = 5'd5;
      #1;
      checks++;
      if (dataOut0 !== 32'd879) begin
         errors++; $display("FAIL same_addr_before_edge got=%0d exp=879", dataOut0);
      end
      step();
      regWrite = 1'b0;
      #1;
      checks++;
      if (dataOut0 !== 32'd36) begin
         errors++; $display("FAIL same_addr_after_edge got=%0d exp=36", dataOut0);
      end
   endtask

   task automatic test_x0();
      regWrite = 1'b1; writeAddr = 5'd0; dataIn = 32'hDEADBEEF;
      step();
      regWrite = 1'b0;
      readAddr0 = 5'd0; readAddr1 = 5'd0;
      #1;
      checks++;
      if (dataOut0 !== 32'd0) begin
         errors++; $display("FAIL x0_rd0 got=%0h exp=0", dataOut0);
      end
      checks++;
      if (dataOut1 !== 32'd0) begin
         errors++; $display("FAIL x0_rd1 got=%0h exp=0", dataOut1);
      end
      readAddr1 = 5'd2;
      #1;
      checks++;
      if (dataOut1 !== 32'd512) begin
         errors++; $display("FAIL x0_neighbor_addr2 got=%0d exp=512", dataOut1);
      end
   endtask

   task automatic test_write_disabled();
      regWrite = 1'b0; writeAddr = 5'd2; dataIn = 32'd7;
      step();
      readAddr0 = 5'd2;
      #1;
      checks++;
      if (dataOut0 !== 32'd512) begin
         errors++; $display("FAIL wr_disabled_addr2 got=%0d exp=512", dataOut0);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp0;
      logic [31:0] exp1;
      regWrite = 1'b1;
      for (int k = 1; k < 32; k++) begin
         writeAddr = 5'(k);
         dataIn = 32'h1000_0000 + 32'(k * 3);
         step();
      end
      regWrite = 1'b0;
      for (int k = 0; k < 32; k++) begin
         readAddr0 = 5'(k);
         readAddr1 = 5'(31 - k);
         exp0 = (k == 0) ? 32'd0 : 32'h1000_0000 + 32'(k * 3);
         exp1 = (k == 31) ? 32'd0 : 32'h1000_0000 + 32'((31 - k) * 3);
         #1;
         checks++;
         if (dataOut0 !== exp0) begin
            errors++; $display("FAIL b2b_rd0 addr=%0d got=%0h exp=%0h", k, dataOut0, exp0);
         end
         checks++;
         if (dataOut1 !== exp1) begin
            errors++; $display("FAIL b2b_rd1 addr=%0d got=%0h exp=%0h", 31 - k, dataOut1, exp1);
         end
      end
   endtask

   task automatic test_reset_priority();
      rst = 1'b1; regWrite = 1'b1; writeAddr = 5'd9; dataIn = 32'd100;
      step();
      rst = 1'b0; regWrite = 1'b0;
      for (int k = 0; k < 32; k++) begin
         readAddr0 = 5'(k);
         readAddr1 = 5'(31 - k);
         #1;
         checks++;
         if (dataOut0 !== 32'd0) begin
            errors++; $display("FAIL rst_prio_rd0 addr=%0d got=%0h exp=0", k, dataOut0);
         end
         checks++;
         if (dataOut1 !== 32'd0) begin
            errors++; $display("FAIL rst_prio_rd1 addr=%0d got=%0h exp=0", 31 - k, dataOut1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_seq_write();
      test_same_addr();
      test_x0();
      test_write_disabled();
      test_back_to_back();
      test_reset_priority();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
